// File: rtl/dram_stream_reader.sv
// Credit-based DDR3 read-request engine that streams a block of words into a
// local FWFT FIFO and out on a valid/ready interface (one-shot or looping).
module dram_stream_reader #(
    parameter int APP_ADDR_WIDTH = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int LEN_WIDTH      = 24,
    parameter int ADDR_STEP      = 8,
    parameter int FIFO_DEPTH     = 32
) (
    input  logic                      clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic                      i_stop,
    input  logic                      i_loop,
    input  logic [APP_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [LEN_WIDTH-1:0]      i_num_words,
    input  logic                      i_calib_done,
    output logic                      o_rd_en,
    output logic [APP_ADDR_WIDTH-1:0] o_addr,
    input  logic                      i_mem_ready,
    input  logic [APP_DATA_WIDTH-1:0] i_mem_data,
    input  logic                      i_mem_data_valid,
    output logic [APP_DATA_WIDTH-1:0] o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT_CAL, ISSUE, DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [APP_ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]      num_q, num_d;
    logic                      loop_q, loop_d;
    logic [APP_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]      issued_q, issued_d;
    logic [CNT_W-1:0]          outstanding_q, outstanding_d;
    logic                      abort_q, abort_d;
    logic                      done_q, done_d;
    logic                      overflow_q, overflow_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [APP_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic             fifo_empty, fifo_full;
    logic [CNT_W:0]   in_flight;
    logic             has_credit, rd_en, accept, ret, stop_hit, discard;
    logic             pop, push_req, push;

    // Credit covers both stored words and words still in flight, so a return can always be stored.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        in_flight  = {1'b0, count_q} + {1'b0, outstanding_q};
        has_credit = (in_flight < (CNT_W + 1)'(FIFO_DEPTH));
        rd_en      = (state_q == ISSUE) && i_calib_done && has_credit;
        accept     = rd_en && i_mem_ready;
        ret        = i_mem_data_valid && (outstanding_q != '0);
        stop_hit   = i_stop && (state_q != IDLE);
        discard    = abort_q || stop_hit;
        pop        = !fifo_empty && !abort_q && i_ready;
        push_req   = ret && !discard;
        push       = push_req && (!fifo_full || pop);
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        overflow_d    = overflow_q | (push_req && fifo_full && !pop);
        if (stop_hit) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        case ({accept, ret})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        num_d    = num_q;
        loop_d   = loop_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        abort_d  = abort_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    base_d   = i_base_addr;
                    num_d    = i_num_words;
                    loop_d   = i_loop;
                    addr_d   = i_base_addr;
                    issued_d = '0;
                    abort_d  = 1'b0;
                    if (i_num_words == '0) done_d = 1'b1;
                    else state_d = WAIT_CAL;
                end
            end
            WAIT_CAL: begin
                if (i_stop) begin
                    state_d = DRAIN;
                    abort_d = 1'b1;
                end else if (i_calib_done) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The wrapped or final address is computed in the accepting cycle, so no bubble.
                if (accept) begin
                    if ((issued_q + LEN_WIDTH'(1)) == num_q && loop_q) begin
                        addr_d   = base_q;
                        issued_d = '0;
                    end else begin
                        addr_d   = addr_q + APP_ADDR_WIDTH'(ADDR_STEP);
                        issued_d = issued_q + LEN_WIDTH'(1);
                        if ((issued_q + LEN_WIDTH'(1)) == num_q) state_d = DRAIN;
                    end
                end
                if (i_stop) begin
                    state_d = DRAIN;
                    abort_d = 1'b1;
                end
            end
            DRAIN: begin
                if (i_stop) abort_d = 1'b1;
                if (outstanding_q == '0 && fifo_empty) begin
                    state_d = IDLE;
                    abort_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            base_q        <= '0;
            num_q         <= '0;
            loop_q        <= 1'b0;
            addr_q        <= '0;
            issued_q      <= '0;
            outstanding_q <= '0;
            abort_q       <= 1'b0;
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            num_q         <= num_d;
            loop_q        <= loop_d;
            addr_q        <= addr_d;
            issued_q      <= issued_d;
            outstanding_q <= outstanding_d;
            abort_q       <= abort_d;
            done_q        <= done_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage array carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= i_mem_data;
    end

    assign o_rd_en    = rd_en;
    assign o_addr     = addr_q;
    assign o_valid    = !fifo_empty && !abort_q;
    assign o_data     = o_valid ? mem_q[rd_ptr_q] : '0;
    assign o_busy     = (state_q != IDLE);
    assign o_done     = done_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_dram_stream_reader.sv
// Directed bench for dram_stream_reader: a latency-5 memory model feeds returns,
// a table of one-shot transfers plus hand-written multi-cycle sequences.
module tb_dram_stream_reader;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int LW = 24;
    localparam int DEPTH = 32;
    localparam int LAT = 5;

    logic          clk;
    logic          i_rst_n;
    logic          i_start, i_stop, i_loop;
    logic [AW-1:0] i_base_addr;
    logic [LW-1:0] i_num_words;
    logic          i_calib_done;
    logic          o_rd_en;
    logic [AW-1:0] o_addr;
    logic          i_mem_ready;
    logic [DW-1:0] i_mem_data;
    logic          i_mem_data_valid;
    logic [DW-1:0] o_data;
    logic          o_valid, i_ready, o_busy, o_done, o_overflow;

    dram_stream_reader #(
        .APP_ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .LEN_WIDTH(LW),
        .ADDR_STEP(8), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_loop(i_loop), .i_base_addr(i_base_addr), .i_num_words(i_num_words),
        .i_calib_done(i_calib_done), .o_rd_en(o_rd_en), .o_addr(o_addr),
        .i_mem_ready(i_mem_ready), .i_mem_data(i_mem_data),
        .i_mem_data_valid(i_mem_data_valid), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done), .o_overflow(o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(int n, logic [AW-1:0] a);
        return {32'(n), 64'h0123_4567_89AB_CDEF, 4'h0, a};
    endfunction

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } ret_t;

    int            cyc = 0;
    logic [AW-1:0] acc_addr[$];
    int            acc_cyc[$];
    ret_t          pend[$];
    logic [DW-1:0] out_q[$];
    int            done_cnt = 0, stall_err = 0, calib_err = 0, busy_err = 0;
    logic          prev_wait = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    bit            toggle_mode = 1'b0;

    // Posedge observer: accepts, stream pops, done pulses and protocol rules.
    initial begin
        forever begin
            @(posedge clk);
            if (o_rd_en && i_mem_ready) begin
                pend.push_back('{cyc + LAT, mk(acc_addr.size(), o_addr)});
                acc_addr.push_back(o_addr);
                acc_cyc.push_back(cyc);
            end
            if (o_valid && i_ready) out_q.push_back(o_data);
            if (o_done) begin
                done_cnt++;
                if (o_busy) busy_err++;
            end
            if (o_rd_en && !i_calib_done) calib_err++;
            if (prev_wait && o_rd_en && o_addr !== prev_addr) stall_err++;
            prev_wait = o_rd_en && !i_mem_ready;
            prev_addr = o_addr;
            cyc++;
        end
    end

    // Memory model: returns each accepted request LAT cycles later, in order.
    initial begin
        i_mem_ready = 1'b1;
        i_mem_data_valid = 1'b0;
        i_mem_data = '0;
        forever begin
            @(negedge clk);
            i_mem_ready = toggle_mode ? ~i_mem_ready : 1'b1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                i_mem_data_valid = 1'b1;
                i_mem_data = pend[0].d;
                pend.delete(0);
            end else begin
                i_mem_data_valid = 1'b0;
                i_mem_data = '0;
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic start_xfer(logic [AW-1:0] b, int n, bit lp);
        i_base_addr = b;
        i_num_words = LW'(n);
        i_loop = lp;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(int db, int budget, string name);
        int t = 0;
        while (done_cnt == db && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, 128'(done_cnt > db), 128'(1));
    endtask

    task automatic wait_acc(int target, int budget, string name);
        int t = 0;
        while (acc_addr.size() < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, 128'(acc_addr.size() >= target), 128'(1));
    endtask

    typedef struct {
        logic [AW-1:0] base;
        int            num;
        bit            toggle;
        logic [AW-1:0] last_addr;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int ab, ob, db, werr, x, verr, out_stop;
        logic [AW-1:0] exp_loop[10];

        vecs[0] = '{28'h0000100, 4, 1'b0, 28'h0000118};
        vecs[1] = '{28'h0000200, 7, 1'b1, 28'h0000230};
        vecs[2] = '{28'hFFFFFF0, 4, 1'b0, 28'h0000008};
        vecs[3] = '{28'h0000007, 1, 1'b1, 28'h0000007};
        exp_loop = '{28'h40, 28'h48, 28'h50, 28'h40, 28'h48,
                     28'h50, 28'h40, 28'h48, 28'h50, 28'h40};

        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_stop = 1'b0;
        i_loop = 1'b0;
        i_base_addr = '0;
        i_num_words = '0;
        i_calib_done = 1'b1;
        i_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", 128'({o_rd_en, o_valid, o_busy, o_done, o_overflow, o_addr}), 128'(0));
        i_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // One-shot transfers from the table, some with a stalling controller.
        for (int i = 0; i < 4; i++) begin
            ab = acc_addr.size();
            ob = out_q.size();
            db = done_cnt;
            toggle_mode = vecs[i].toggle;
            start_xfer(vecs[i].base, vecs[i].num, 1'b0);
            wait_done(db, 1000, $sformatf("row%0d_done_seen", i));
            repeat (3) @(negedge clk);
            toggle_mode = 1'b0;
            check($sformatf("row%0d_accepts", i), 128'(acc_addr.size() - ab), 128'(vecs[i].num));
            check($sformatf("row%0d_last_addr", i), 128'(acc_addr[$]), 128'(vecs[i].last_addr));
            werr = 0;
            for (int k = 0; k < vecs[i].num; k++) begin
                if (ab + k >= acc_addr.size() || acc_addr[ab + k] !== vecs[i].base + AW'(8 * k)) werr++;
                if (ob + k >= out_q.size() || out_q[ob + k] !== mk(ab + k, vecs[i].base + AW'(8 * k))) werr++;
            end
            check($sformatf("row%0d_order_errors", i), 128'(werr), 128'(0));
            check($sformatf("row%0d_words_out", i), 128'(out_q.size() - ob), 128'(vecs[i].num));
            check($sformatf("row%0d_done_pulses", i), 128'(done_cnt - db), 128'(1));
            check($sformatf("row%0d_busy_ovf", i), 128'({o_busy, o_overflow}), 128'(0));
        end

        // Backpressure: consumer stalled, credit must stop requests at FIFO_DEPTH.
        ab = acc_addr.size();
        ob = out_q.size();
        db = done_cnt;
        i_ready = 1'b0;
        start_xfer(28'h1000, 100, 1'b0);
        repeat (200) @(negedge clk);
        check("bp_accepts_at_full", 128'(acc_addr.size() - ab), 128'(DEPTH));
        check("bp_rd_en_low", 128'(o_rd_en), 128'(0));
        check("bp_valid_overflow", 128'({o_valid, o_overflow}), 128'(2));
        check("bp_head_word", o_data, mk(ab, 28'h1000));
        i_ready = 1'b1;
        wait_done(db, 2000, "bp_done_seen");
        repeat (2) @(negedge clk);
        werr = 0;
        for (int k = 0; k < 100; k++)
            if (ob + k >= out_q.size() || out_q[ob + k] !== mk(ab + k, 28'h1000 + AW'(8 * k))) werr++;
        check("bp_words_out", 128'(out_q.size() - ob), 128'(100));
        check("bp_order_errors", 128'(werr), 128'(0));
        check("bp_accepts_total", 128'(acc_addr.size() - ab), 128'(100));

        // Loop wrap then abort.
        ab = acc_addr.size();
        start_xfer(28'h40, 3, 1'b1);
        wait_acc(ab + 10, 100, "loop_ten_accepts");
        werr = 0;
        for (int k = 0; k < 10; k++) begin
            if (ab + k >= acc_addr.size() || acc_addr[ab + k] !== exp_loop[k]) werr++;
            if (ab + k >= acc_cyc.size() || acc_cyc[ab + k] != acc_cyc[ab] + k) werr++;
        end
        check("loop_addr_seq_errors", 128'(werr), 128'(0));
        db = done_cnt;
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        i_loop = 1'b0;
        out_stop = out_q.size();
        verr = 0;
        for (int t = 0; t < 200 && done_cnt == db; t++) begin
            if (o_valid) verr++;
            @(negedge clk);
        end
        check("stop_done_seen", 128'(done_cnt - db), 128'(1));
        check("stop_valid_cycles", 128'(verr), 128'(0));
        check("stop_returns_pending", 128'(pend.size()), 128'(0));
        check("stop_words_after", 128'(out_q.size() - out_stop), 128'(0));
        check("stop_busy", 128'(o_busy), 128'(0));

        // Zero-length start.
        ab = acc_addr.size();
        db = done_cnt;
        start_xfer(28'h900, 0, 1'b0);
        check("zero_done_pulse", 128'({o_done, o_busy}), 128'(2));
        @(negedge clk);
        check("zero_done_single", 128'({o_done, o_busy}), 128'(0));
        repeat (10) @(negedge clk);
        check("zero_no_reads", 128'(acc_addr.size() - ab), 128'(0));

        // Calibration gating.
        ab = acc_addr.size();
        db = done_cnt;
        i_calib_done = 1'b0;
        start_xfer(28'h300, 2, 1'b0);
        repeat (10) @(negedge clk);
        check("cal_no_reads", 128'(acc_addr.size() - ab), 128'(0));
        check("cal_busy", 128'(o_busy), 128'(1));
        i_calib_done = 1'b1;
        x = cyc;
        wait_done(db, 200, "cal_done_seen");
        check("cal_first_req_cycle", 128'(acc_cyc.size() > ab ? acc_cyc[ab] : -1), 128'(x + 1));
        check("cal_accepts", 128'(acc_addr.size() - ab), 128'(2));
        check("cal_rd_en_violations", 128'(calib_err), 128'(0));

        // Reset with requests in flight.
        repeat (3) @(negedge clk);
        ab = acc_addr.size();
        start_xfer(28'h500, 20, 1'b0);
        wait_acc(ab + 5, 50, "rst_five_accepts");
        i_rst_n = 1'b0;
        #1;
        check("rst_outputs", {o_rd_en, o_valid, o_busy, o_done, o_overflow, o_addr} | o_data, 128'(0));
        @(negedge clk);
        i_rst_n = 1'b1;
        ob = out_q.size();
        repeat (15) @(negedge clk);
        check("rst_late_pushes", 128'(out_q.size() - ob), 128'(0));
        check("rst_valid_busy_ovf", 128'({o_valid, o_busy, o_overflow}), 128'(0));
        check("rst_model_drained", 128'(pend.size()), 128'(0));
        ab = acc_addr.size();
        ob = out_q.size();
        db = done_cnt;
        start_xfer(28'h600, 2, 1'b0);
        wait_done(db, 200, "post_rst_done_seen");
        repeat (2) @(negedge clk);
        check("post_rst_word0", out_q.size() > ob ? out_q[ob] : '0, mk(ab, 28'h600));
        check("post_rst_word1", out_q.size() > ob + 1 ? out_q[ob + 1] : '0, mk(ab + 1, 28'h608));

        check("addr_stable_violations", 128'(stall_err), 128'(0));
        check("done_while_busy", 128'(busy_err), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dram_stream_reader.md
Name: dram_stream_reader

Overview:
- Upstream read-request engine for the DRAM controller's user-side port.
- Streams a contiguous block of 128-bit pulse-shape words from DDR3 into a local first-word-fall-through (FWFT) FIFO.
- Presents the words on a valid/ready stream to the pulse playback path.
- Supports one-shot and continuous-loop playback.
- Flow control is credit-based, so returned read data can never overflow the FIFO.

Parameters:
- APP_ADDR_WIDTH, 28, width of the controller address bus.
- APP_DATA_WIDTH, 128, width of one controller data word.
- LEN_WIDTH, 24, width of the word-count input.
- ADDR_STEP, 8, address increment per 128-bit word (BL8 on a x16 part).
- FIFO_DEPTH, 32, output FIFO depth in words; power of 2, at least 4.

Ports:
- clk  in  1  controller user clock (o_clk of the DRAM controller).
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse that begins a transfer.
- i_stop  in  1  one-cycle pulse that aborts a transfer (loop or one-shot).
- i_loop  in  1  sampled at start; 1 = wrap to base address after the last word.
- i_base_addr  in  APP_ADDR_WIDTH  first word address, sampled at start.
- i_num_words  in  LEN_WIDTH  words per pass, sampled at start.
- i_calib_done  in  1  controller o_init_calib_complete.
- o_rd_en  out  1  read request to the controller i_rd_en.
- o_addr  out  APP_ADDR_WIDTH  read address to the controller i_addr.
- i_mem_ready  in  1  controller o_ready.
- i_mem_data  in  APP_DATA_WIDTH  controller o_data.
- i_mem_data_valid  in  1  controller o_data_valid.
- o_data  out  APP_DATA_WIDTH  stream data (FIFO head).
- o_valid  out  1  stream valid.
- i_ready  in  1  stream ready from the consumer.
- o_busy  out  1  transfer in progress.
- o_done  out  1  one-cycle pulse when a transfer ends.
- o_overflow  out  1  sticky error flag: data returned while the FIFO was full.

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, all counters 0. Asserting i_rst_n low mid-transfer aborts immediately; data still in flight after release is discarded (the outstanding count is 0 after reset).
- FSM states:
  - IDLE: on i_start, latch base/num/loop.
    - If num == 0: no reads; o_done pulses the next cycle; stay IDLE.
    - Otherwise: go to WAIT_CAL; o_busy = 1.
    - i_start while not in IDLE is ignored.
  - WAIT_CAL: go to ISSUE when i_calib_done = 1.
  - ISSUE:
    - o_rd_en = 1 whenever credit > 0, where credit = FIFO_DEPTH − fifo_count − outstanding.
    - A request is accepted in any cycle with o_rd_en && i_mem_ready. o_addr is held stable until acceptance.
    - On acceptance: outstanding += 1; addr += ADDR_STEP; issued += 1.
    - When issued reaches num:
      - loop = 1: addr reloads base, issued reloads 0, stay in ISSUE.
      - loop = 0: go to DRAIN.
    - If the last acceptance and the wrap/exit coincide, the wrapped or final address is used in the next cycle with no bubble.
  - DRAIN: no requests. Exit to IDLE when outstanding == 0 and the FIFO is empty. o_done pulses in the cycle the state becomes IDLE; o_busy falls in that same cycle.
- i_stop:
  - In WAIT_CAL or ISSUE: go to DRAIN with abort = 1. An o_rd_en already pending is withdrawn in the next cycle (legal; the controller samples only on ready).
  - With abort = 1: the FIFO is flushed immediately, returned words are decremented from outstanding but not stored, and o_valid is 0.
  - i_stop in IDLE is ignored. i_stop in DRAIN sets abort.
- Read returns: each i_mem_data_valid decrements outstanding and pushes i_mem_data (unless aborting).
  - Push into a full FIFO: the word is dropped and o_overflow is set; it clears only on reset.
  - A simultaneous accept and return leaves outstanding unchanged.
- FIFO:
  - FWFT: o_valid = !empty; o_data = head.
  - Pop on o_valid && i_ready.
  - A word pushed in cycle N is visible on o_valid in cycle N+1.
  - A simultaneous push and pop when full is legal only via pop-first ordering: count stays the same, no overflow.
- Counters: outstanding and fifo_count use clog2(FIFO_DEPTH) + 1 bits. Address arithmetic is modulo 2^APP_ADDR_WIDTH; the wrap at the top of address space is silent.
- o_rd_en never asserts while i_calib_done = 0.

Test Plan:
1. One-shot transfer: base = 0x100, num = 4, loop = 0, mem_ready = 1, data returned 5 cycles after each accept, i_ready = 1 → addresses 0x100, 0x108, 0x110, 0x118 each accepted once; 4 words out in order; o_done one pulse; o_busy falls with it.
2. Backpressure: FIFO_DEPTH = 32, num = 100, i_ready = 0 → after 32 accepts, o_rd_en stays 0; fifo_count = 32, no overflow. Release i_ready → 100 words delivered in order.
3. Loop wrap: base = 0x40, num = 3, loop = 1, run 10 accepts → address sequence 0x40, 0x48, 0x50, 0x40, 0x48, … with no idle cycle at the wrap. i_stop → remaining returns discarded, o_valid = 0, o_done once outstanding reaches 0.
4. Calibration gating and zero length: start with i_calib_done = 0 → no o_rd_en until calib rises, first request the cycle after. Start with num = 0 → o_done the next cycle, o_busy stays 0, no reads.
5. Controller stall: mem_ready toggling 1/0 → o_addr stable while unaccepted; accept count equals num exactly.
6. Reset mid-transfer: i_rst_n low with 5 outstanding → all outputs 0; after release, late data_valid pulses push nothing and do not underflow outstanding.
